// File: rtl/pipe_pkg.sv
// pipe_pkg: occupancy encoding and packed control-vector layout shared by every stage register
package pipe_pkg;
    typedef enum logic [1:0] {OCC_EMPTY = 2'd0, OCC_ONE = 2'd1, OCC_FULL = 2'd2} occ_e;
    // Fields are ordered by how far down the pipe they travel, so each later boundary keeps a prefix
    localparam int W_REG_WRITE = 1, W_WB_SEL = 2, W_RD = 5, W_EXC = 8, W_CAUSE = 5, W_ERET = 1;
    localparam int W_MEM_READ = 1, W_MEM_WRITE = 1, W_MEM_SIZE = 3;
    localparam int W_ALU_OP = 5, W_ALU_SRC = 1, W_BRANCH = 1, W_JUMP = 1, W_CSR_OP = 3, W_PRIV = 2;
    localparam int OFF_REG_WRITE = 0;
    localparam int OFF_WB_SEL    = OFF_REG_WRITE + W_REG_WRITE;
    localparam int OFF_RD        = OFF_WB_SEL + W_WB_SEL;
    localparam int OFF_EXC       = OFF_RD + W_RD;
    localparam int OFF_CAUSE     = OFF_EXC + W_EXC;
    localparam int OFF_ERET      = OFF_CAUSE + W_CAUSE;
    localparam int OFF_MEM_READ  = OFF_ERET + W_ERET;
    localparam int OFF_MEM_WRITE = OFF_MEM_READ + W_MEM_READ;
    localparam int OFF_MEM_SIZE  = OFF_MEM_WRITE + W_MEM_WRITE;
    localparam int OFF_ALU_OP    = OFF_MEM_SIZE + W_MEM_SIZE;
    localparam int OFF_ALU_SRC   = OFF_ALU_OP + W_ALU_OP;
    localparam int OFF_BRANCH    = OFF_ALU_SRC + W_ALU_SRC;
    localparam int OFF_JUMP      = OFF_BRANCH + W_BRANCH;
    localparam int OFF_CSR_OP    = OFF_JUMP + W_JUMP;
    localparam int OFF_PRIV      = OFF_CSR_OP + W_CSR_OP;
    localparam int PIPE_CTRL_W   = OFF_PRIV + W_PRIV;
    localparam int IFID_CTRL_W   = PIPE_CTRL_W;
    localparam int IDEX_CTRL_W   = PIPE_CTRL_W;
    localparam int EXMEM_CTRL_W  = OFF_ALU_OP;
    localparam int MEMWB_CTRL_W  = OFF_MEM_READ;
endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: upstream/downstream handshake bundle of one pipeline stage register
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = 128,
    parameter int SIDE_W = 33
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [SIDE_W-1:0] in_side;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [SIDE_W-1:0] out_side;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cnt;
    modport master (
        output in_valid, in_ctrl, in_data, in_side, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, out_side, occupancy, stall_cnt
    );
    modport slave (
        input  in_valid, in_ctrl, in_data, in_side, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, out_side, occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one valid+ctrl+data entry; ctrl is zero whenever the entry is invalid
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              clear_data_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            if (clear_data_i) data_q <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            ctrl_q  <= valid_i ? ctrl_i : '0;
            if (valid_i) data_q <= data_i;
        end
    end
    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with optional two-entry skid, flush and stall counter
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = PIPE_CTRL_W,
    parameter int DATA_W     = 128,
    parameter int SIDE_W     = 33,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1
) (
    input logic             clock,
    input logic             reset,
    input logic             flush,
    pipe_stage_skid_if.slave bus
);
    occ_e              occ_q, occ_d;
    logic              ready_q, accept, drain, m_load, s_load, m_valid, s_valid;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [DATA_W-1:0] m_data, s_data;
    logic [SIDE_W-1:0] side_q;
    logic [15:0]       stall_q;
    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = m_valid & bus.out_ready;
    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q   <= OCC_EMPTY;
            ready_q <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            ready_q <= occ_d != OCC_FULL;
        end
    end
    always_comb begin
        occ_d = occ_q;
        unique case (occ_q)
            OCC_EMPTY: occ_d = accept ? OCC_ONE : OCC_EMPTY;
            OCC_ONE:   occ_d = (accept & ~drain) ? OCC_FULL : ((drain & ~accept) ? OCC_EMPTY : OCC_ONE);
            OCC_FULL:  occ_d = drain ? OCC_ONE : OCC_FULL;
            default:   occ_d = OCC_EMPTY;
        endcase
        if (flush) occ_d = OCC_EMPTY;
    end
    // The skid slot fills only when main is busy and not leaving; it empties into main on a drain.
    always_comb begin
        m_load = drain | (occ_q == OCC_EMPTY);
        s_load = (accept & (occ_q == OCC_ONE) & ~drain) | ((occ_q == OCC_FULL) & drain);
    end
    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk_i(clock), .rst_i(reset), .load_i(m_load), .clear_i(flush),
        .clear_data_i(CLEAR_DATA != 0), .valid_i(s_valid | accept),
        .ctrl_i(s_valid ? s_ctrl : bus.in_ctrl), .data_i(s_valid ? s_data : bus.in_data),
        .valid_o(m_valid), .ctrl_o(m_ctrl), .data_o(m_data)
    );
    generate
        if (SKID != 0) begin : g_skid
            pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk_i(clock), .rst_i(reset), .load_i(s_load), .clear_i(flush),
                .clear_data_i(CLEAR_DATA != 0), .valid_i(accept),
                .ctrl_i(bus.in_ctrl), .data_i(bus.in_data),
                .valid_o(s_valid), .ctrl_o(s_ctrl), .data_o(s_data)
            );
            assign bus.in_ready = ready_q;
        end else begin : g_single
            assign s_valid      = 1'b0;
            assign s_ctrl       = '0;
            assign s_data       = '0;
            assign bus.in_ready = bus.out_ready | ~m_valid;
        end
    endgenerate
    always_ff @(posedge clock) begin
        if (reset) begin
            side_q  <= '0;
            stall_q <= '0;
        end else begin
            side_q <= bus.in_side;
            if (m_valid & ~bus.out_ready & ~&stall_q) stall_q <= stall_q + 16'd1;
        end
    end
    assign bus.out_valid = m_valid;
    assign bus.out_ctrl  = m_ctrl;
    assign bus.out_data  = m_data;
    assign bus.out_side  = side_q;
    assign bus.occupancy = occ_q;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: SKID=1/CLEAR_DATA=1 and SKID=0/CLEAR_DATA=0 copies driven in lockstep against a FIFO model
module tb_pipe_stage_skid;
    import pipe_pkg::*;
    localparam int CW = PIPE_CTRL_W;
    logic clk = 1'b0, rst = 1'b1, fl = 1'b0;
    always #5 clk = ~clk;
    pipe_stage_skid_if b0 ();
    pipe_stage_skid_if b1 ();
    pipe_stage_skid #(.SKID(0), .CLEAR_DATA(0)) dut0 (.clock(clk), .reset(rst), .flush(fl), .bus(b0));
    pipe_stage_skid #(.SKID(1), .CLEAR_DATA(1)) dut1 (.clock(clk), .reset(rst), .flush(fl), .bus(b1));
    typedef struct { logic [CW-1:0] c; logic [127:0] d; } ent_t;
    typedef struct { bit v; int c; bit o; bit f; bit ev; int ec; int eo; bit er; int es; } vec_t;
    // Model: index 0 is the single-register copy (depth 1), index 1 the skid copy (depth 2)
    ent_t         mb [2][2];
    int           mn [2] = '{0, 0};
    logic [15:0]  mst [2];
    bit           dk [2];
    logic [127:0] dexp [2];
    logic [32:0]  mside;
    int n_chk = 0, n_err = 0, cyc = 0;
    bit chk_en = 1'b1;
    vec_t vt [19];

    task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic check_out(input int k);
        logic ov;
        logic [CW-1:0] oc;
        logic [127:0] od;
        logic [32:0] os;
        logic [1:0] oo;
        logic [15:0] ost;
        ov  = k != 0 ? b1.out_valid : b0.out_valid;
        oc  = k != 0 ? b1.out_ctrl  : b0.out_ctrl;
        od  = k != 0 ? b1.out_data  : b0.out_data;
        os  = k != 0 ? b1.out_side  : b0.out_side;
        oo  = k != 0 ? b1.occupancy : b0.occupancy;
        ost = k != 0 ? b1.stall_cnt : b0.stall_cnt;
        chk("out_valid", k, ov, mn[k] > 0);
        chk("out_ctrl", k, oc, mn[k] > 0 ? mb[k][0].c : '0);
        if (mn[k] > 0) chk("out_data", k, od, mb[k][0].d);
        else if (dk[k]) chk("out_data_idle", k, od, dexp[k]);
        chk("occupancy", k, oo, 128'(mn[k]));
        chk("stall_cnt", k, ost, mst[k]);
        chk("out_side", k, os, mside);
    endtask

    task automatic cycle(input bit v, input logic [CW-1:0] c, input logic [127:0] d,
                         input logic [32:0] s, input bit o, input bit f, input bit r);
        bit rdy [2];
        bit acc, drn;
        b0.in_valid = v; b1.in_valid = v;
        b0.in_ctrl = c;  b1.in_ctrl = c;
        b0.in_data = d;  b1.in_data = d;
        b0.in_side = s;  b1.in_side = s;
        b0.out_ready = o; b1.out_ready = o;
        fl = f; rst = r;
        rdy[0] = mn[0] == 0 || o;
        rdy[1] = mn[1] < 2;
        #1;
        if (chk_en && !r) begin
            chk("in_ready", 0, b0.in_ready, rdy[0]);
            chk("in_ready", 1, b1.in_ready, rdy[1]);
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                mn[k] = 0; mst[k] = '0; dk[k] = 1'b1; dexp[k] = '0;
            end else begin
                if (mn[k] > 0 && !o && mst[k] != 16'hFFFF) mst[k]++;
                if (f) begin
                    dk[k]   = k == 1 || mn[k] > 0;
                    dexp[k] = (k == 1 || mn[k] == 0) ? '0 : mb[k][0].d;
                    mn[k]   = 0;
                end else begin
                    drn = mn[k] > 0 && o;
                    acc = v && rdy[k];
                    if (drn) begin
                        mb[k][0] = mb[k][1];
                        mn[k]--;
                        if (mn[k] == 0) dk[k] = 1'b0;
                    end
                    if (acc) begin
                        mb[k][mn[k]].c = c;
                        mb[k][mn[k]].d = d;
                        mn[k]++;
                    end
                end
            end
        end
        mside = r ? '0 : s;
        #1;
        if (chk_en) for (int k = 0; k < 2; k++) check_out(k);
        @(negedge clk);
    endtask

    initial begin
        logic [CW-1:0] rc;
        logic [127:0] rd;
        logic [32:0] rs;
        // v, c, o, f | exp valid, ctrl, occupancy, in_ready, stall_cnt  (skid copy)
        vt = '{'{1, 1, 1, 0, 1, 1, 1, 1, 0}, '{1, 2, 1, 0, 1, 2, 1, 1, 0},
               '{1, 3, 1, 0, 1, 3, 1, 1, 0}, '{1, 4, 1, 0, 1, 4, 1, 1, 0},
               '{1, 5, 1, 0, 1, 5, 1, 1, 0}, '{0, 0, 1, 0, 0, 0, 0, 1, 0},
               '{1, 6, 1, 0, 1, 6, 1, 1, 0}, '{1, 7, 1, 0, 1, 7, 1, 1, 0},
               '{1, 8, 0, 0, 1, 7, 2, 0, 1}, '{1, 9, 0, 0, 1, 7, 2, 0, 2},
               '{1, 9, 1, 0, 1, 8, 1, 1, 2}, '{1, 9, 1, 0, 1, 9, 1, 1, 2},
               '{0, 0, 1, 0, 0, 0, 0, 1, 2}, '{1, 10, 0, 0, 1, 10, 1, 1, 2},
               '{1, 11, 0, 0, 1, 10, 2, 0, 3}, '{1, 12, 0, 1, 0, 0, 0, 1, 4},
               '{0, 0, 1, 0, 0, 0, 0, 1, 4}, '{1, 13, 1, 0, 1, 13, 1, 1, 4},
               '{1, 14, 1, 1, 0, 0, 0, 1, 4}};
        cycle(0, '0, '0, '0, 1, 0, 1);
        cycle(0, '0, '0, '1, 1, 0, 1);
        foreach (vt[i]) begin
            cycle(vt[i].v, CW'(vt[i].c), {96'd0, vt[i].f ? 32'hDEAD_BEEF : 32'h1000 + 32'(vt[i].c)},
                  {33{i[0]}}, vt[i].o, vt[i].f, 0);
            chk("tbl_valid", 1, b1.out_valid, vt[i].ev);
            chk("tbl_ctrl", 1, b1.out_ctrl, 128'(vt[i].ec));
            chk("tbl_occ", 1, b1.occupancy, 128'(vt[i].eo));
            chk("tbl_ready", 1, b1.in_ready, vt[i].er);
            chk("tbl_stall", 1, b1.stall_cnt, 128'(vt[i].es));
            if (vt[i].ev || vt[i].f)
                chk("tbl_data", 1, b1.out_data, vt[i].ev ? {96'd0, 32'h1000 + 32'(vt[i].ec)} : 128'd0);
        end
        cycle(1, CW'(20), 128'h20, '0, 1, 0, 0);
        b0.in_valid = 1'b1; b1.in_valid = 1'b1;
        b0.out_ready = 1'b0; b1.out_ready = 1'b0;
        #1;
        chk("comb_ready_low", 0, b0.in_ready, 0);
        chk("reg_ready_hold", 1, b1.in_ready, 1);
        b0.out_ready = 1'b1; b1.out_ready = 1'b1;
        #1;
        chk("comb_ready_high", 0, b0.in_ready, 1);
        cycle(1, CW'(21), 128'h21, '1, 1, 0, 0);
        chk("handoff_valid", 0, b0.out_valid, 1);
        chk("handoff_ctrl", 0, b0.out_ctrl, 21);
        for (int i = 0; i < 3; i++) cycle(1, CW'(30 + i), 128'(30 + i), 33'(i), 0, 0, 0);
        cycle(1, CW'(40), 128'h40, '1, 0, 0, 1);
        chk("rst_occ", 1, b1.occupancy, 0);
        chk("rst_stall", 1, b1.stall_cnt, 0);
        chk("rst_side", 1, b1.out_side, 0);
        for (int i = 0; i < 3000; i++) begin
            rc = CW'({$urandom, $urandom});
            rd = {$urandom, $urandom, $urandom, $urandom};
            rs = 33'({$urandom, $urandom});
            cycle($urandom_range(0, 3) != 0, rc, rd, rs, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0, $urandom_range(0, 400) == 0);
        end
        cycle(1, CW'(50), 128'h50, '0, 0, 0, 0);
        cycle(1, CW'(51), 128'h51, '1, 0, 0, 0);
        chk_en = 1'b0;
        for (int i = 0; i < 70000; i++) cycle(0, '0, '0, 33'($urandom), 0, 0, 0);
        chk_en = 1'b1;
        cycle(0, '0, '0, 33'h1_2345_6789, 0, 0, 0);
        chk("sat_stall", 1, b1.stall_cnt, 16'hFFFF);
        chk("sat_stall", 0, b0.stall_cnt, 16'hFFFF);
        cycle(0, '0, '0, '0, 0, 1, 0);
        chk("sat_after_flush", 1, b1.stall_cnt, 16'hFFFF);
        cycle(0, '0, '0, '0, 0, 0, 1);
        chk("sat_rst_clear", 1, b1.stall_cnt, 0);
        chk("sat_rst_clear", 0, b0.stall_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
